snd_cmd_mailbox: RTL and testbench

//  Parametrised main-CPU -> sound-Z80 command mailbox, successor to the fixed two-latch scheme.
//  NUM_CH channels, each a DEPTH-entry FIFO (DEPTH=1 gives classic latch behaviour), with per-channel INT/NMI routing.

---
 rtl/snd_cmd_mailbox_pkg.sv | 15 +
 rtl/snd_cmd_mailbox_if.sv | 38 +++
 rtl/snd_cmd_fifo.sv | 88 ++++++++
 rtl/snd_cmd_mailbox.sv | 127 ++++++++++++
 tb/tb_snd_cmd_mailbox.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snd_cmd_mailbox_pkg.sv
// Shared constants and types for the main-CPU -> sound-CPU command mailbox.
//   SND_NMI_VECTOR : Z80 NMI entry address, used to detect NMI acknowledge
//   SND_IM0_HI     : fixed upper bits of the IM0 status/vector byte
//   snd_ch_t       : command channel selector
//   ptr_w()        : pointer width for a power-of-2 depth, never below 1 bit
package snd_cmd_mailbox_pkg;
  localparam logic [15:0] SND_NMI_VECTOR = 16'h0066;
  localparam logic [1:0]  SND_IM0_HI     = 2'b11;

  typedef logic [1:0] snd_ch_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/snd_cmd_mailbox_if.sv
// Bus bundle between the main-CPU decode / Z80 bus and the mailbox.
//   cmd_*          : push strobe, channel and byte from the main-CPU decode
//   z80_*          : Z80 address and control strobes
//   ext_irq_n      : YM2151 interrupt, merged into INT
//   rd_data/rd_sel : byte to mux onto Z80 DI and its select
//   int_n/nmi_n    : Z80 interrupt lines
// slave = mailbox side, master = CPU/bus side.
interface snd_cmd_mailbox_if;
  import snd_cmd_mailbox_pkg::*;

  logic        cmd_wr;
  snd_ch_t     cmd_ch;
  logic [7:0]  cmd_data;
  logic [7:0]  z80_addr;
  logic        z80_iorq_n;
  logic        z80_rd_n;
  logic        z80_wr_n;
  logic        z80_m1_n;
  logic        z80_mreq_n;
  logic [15:0] z80_fetch_a;
  logic        ext_irq_n;
  logic [7:0]  rd_data;
  logic        rd_sel;
  logic        int_n;
  logic        nmi_n;

  modport slave (
    input  cmd_wr, cmd_ch, cmd_data, z80_addr, z80_iorq_n, z80_rd_n, z80_wr_n,
           z80_m1_n, z80_mreq_n, z80_fetch_a, ext_irq_n,
    output rd_data, rd_sel, int_n, nmi_n
  );

  modport master (
    output cmd_wr, cmd_ch, cmd_data, z80_addr, z80_iorq_n, z80_rd_n, z80_wr_n,
           z80_m1_n, z80_mreq_n, z80_fetch_a, ext_irq_n,
    input  rd_data, rd_sel, int_n, nmi_n
  );
endinterface

// File: rtl/snd_cmd_fifo.sv
// One command channel: DEPTH-entry byte FIFO with flush and sticky overflow.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write data_i at tail (full: overwrite newest or drop)
//   pop_i        : advance head (ignored when empty)
//   flush_i      : empty the FIFO and clear overflow; beats a same-cycle push
//   head_o       : current head byte (combinational)
//   empty_o      : FIFO holds no entries
//   ovf_o        : sticky, set by a push that found the FIFO full
module snd_cmd_fifo
  import snd_cmd_mailbox_pkg::*;
#(
  parameter int DEPTH     = 1,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  logic [7:0] data_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       ovf_o
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic          full, do_pop, push_acc, wr_en;
  logic [PW-1:0] wr_addr;

  // Pointers wrap modulo DEPTH; a single-entry FIFO keeps them at 0.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction
  function automatic logic [PW-1:0] dec(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p - 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push to a full FIFO still fits.
  assign push_acc = push_i & (~full | do_pop);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_ptr_q;
    if (!flush_i && push_i) begin
      if (push_acc) begin
        wr_en = 1'b1;
      end else if (OVERWRITE) begin
        wr_en   = 1'b1;
        wr_addr = dec(wr_ptr_q);  // newest entry sits just behind the tail
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= inc(wr_ptr_q);
      if (do_pop)   rd_ptr_q <= inc(rd_ptr_q);
      if (push_i && !push_acc) ovf_q <= 1'b1;
      case ({push_acc, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign ovf_o  = ovf_q;
endmodule

// File: rtl/snd_cmd_mailbox.sv
// Main-CPU -> sound-Z80 command mailbox: NUM_CH FIFO channels with per-channel
// INT/NMI routing, an optional periodic NMI timer and the IM0 status byte.
//   CLK_32M : system clock
//   reset   : synchronous, active-high
//   pause   : freezes Z80-side pops/flushes and the NMI timer
//   bus     : command/Z80 bundle (slave side)
//   ready   : per-channel non-empty flag
//   ovf     : per-channel sticky overflow flag
// Channel c: data port BASE_ADDR+2c (IN pops), ack port BASE_ADDR+2c+1 (OUT flushes).
module snd_cmd_mailbox
  import snd_cmd_mailbox_pkg::*;
#(
  parameter int         NUM_CH     = 2,
  parameter int         DEPTH      = 1,
  parameter bit         OVERWRITE  = 1'b1,
  parameter logic [7:0] BASE_ADDR  = 8'h02,
  parameter logic [3:0] NMI_MASK   = 4'b0010,
  parameter int         NMI_PERIOD = 0
) (
  input  logic              CLK_32M,
  input  logic              reset,
  input  logic              pause,
  snd_cmd_mailbox_if.slave  bus,
  output logic [NUM_CH-1:0] ready,
  output logic [NUM_CH-1:0] ovf
);
  localparam logic [NUM_CH-1:0] NMI_SEL = NMI_MASK[NUM_CH-1:0];

  logic              iorq_prev_q;
  logic              io_go, im0_ack, nmi_pend;
  logic [NUM_CH-1:0] data_hit;
  logic [7:0]        head [NUM_CH];
  logic [7:0]        rd_data_d;
  logic              rd_sel_d;

  // One Z80 I/O access per IORQ_n falling edge; IM0 acknowledge is not an I/O access.
  always_ff @(posedge CLK_32M) begin
    if (reset) iorq_prev_q <= 1'b1;
    else       iorq_prev_q <= bus.z80_iorq_n;
  end

  assign io_go   = iorq_prev_q & ~bus.z80_iorq_n & bus.z80_m1_n & ~pause;
  assign im0_ack = ~bus.z80_m1_n & ~bus.z80_iorq_n;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [7:0] DATA_ADDR = BASE_ADDR + 8'(2 * gi);
    localparam logic [7:0] ACK_ADDR  = BASE_ADDR + 8'(2 * gi + 1);

    logic empty;

    assign data_hit[gi] = (bus.z80_addr == DATA_ADDR);

    snd_cmd_fifo #(
      .DEPTH     (DEPTH),
      .OVERWRITE (OVERWRITE)
    ) u_fifo (
      .clk_i   (CLK_32M),
      .rst_i   (reset),
      .push_i  (bus.cmd_wr & (bus.cmd_ch == snd_ch_t'(gi))),
      .pop_i   (io_go & ~bus.z80_rd_n & data_hit[gi]),
      .flush_i (io_go & ~bus.z80_wr_n & (bus.z80_addr == ACK_ADDR)),
      .data_i  (bus.cmd_data),
      .head_o  (head[gi]),
      .empty_o (empty),
      .ovf_o   (ovf[gi])
    );

    assign ready[gi] = ~empty;
  end

  // Read data follows the address combinationally; an empty channel reads 0xFF.
  always_comb begin
    rd_data_d = 8'hFF;
    rd_sel_d  = 1'b0;
    if (!reset) begin
      if (im0_ack) begin
        rd_data_d = {SND_IM0_HI, ~ready[0], bus.ext_irq_n, 4'hF};
        rd_sel_d  = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (data_hit[i]) begin
            rd_data_d = ready[i] ? head[i] : 8'hFF;
            rd_sel_d  = ~bus.z80_iorq_n & ~bus.z80_rd_n;
          end
        end
      end
    end
  end

  assign bus.rd_data = rd_data_d;
  assign bus.rd_sel  = rd_sel_d;

  if (NMI_PERIOD > 0) begin : g_tmr
    localparam int TW = ptr_w(NMI_PERIOD);

    logic [TW-1:0] tmr_q;
    logic          pend_q;
    logic          nmi_fetch;

    assign nmi_fetch = ~bus.z80_m1_n & ~bus.z80_mreq_n & (bus.z80_fetch_a == SND_NMI_VECTOR);

    // Set is written after clear so a wrap in the acknowledge cycle keeps NMI pending.
    always_ff @(posedge CLK_32M) begin
      if (reset) begin
        tmr_q  <= '0;
        pend_q <= 1'b0;
      end else begin
        if (nmi_fetch) pend_q <= 1'b0;
        if (!pause) begin
          if (tmr_q == TW'(NMI_PERIOD - 1)) begin
            tmr_q  <= '0;
            pend_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
      end
    end

    assign nmi_pend = pend_q;
  end else begin : g_no_tmr
    assign nmi_pend = 1'b0;
  end

  assign bus.int_n = ~(|(ready & ~NMI_SEL) | ~bus.ext_irq_n);
  assign bus.nmi_n = ~(|(ready & NMI_SEL) | nmi_pend);
endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Four mailboxes share one stimulus: [0] DEPTH=1, [1] DEPTH=4 overwrite,
// [2] DEPTH=4 drop, [3] DEPTH=1 with a 4096-cycle NMI timer.
module tb_snd_cmd_mailbox;
  localparam int OP_IDLE = 0;
  localparam int OP_IN   = 1;
  localparam int OP_OUT  = 2;
  localparam int OP_IM0  = 3;

  logic        clk = 1'b0;
  logic        rst, pause, cmd_wr, iorq_n, rd_n, wr_n, m1_n, mreq_n, ext_n;
  logic [1:0]  cmd_ch;
  logic [7:0]  cmd_data, z80_addr;
  logic [15:0] fetch_a;

  logic [7:0] rd_w    [4];
  logic       sel_w   [4];
  logic       int_w   [4];
  logic       nmi_w   [4];
  logic [1:0] ready_w [4];
  logic [1:0] ovf_w   [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    snd_cmd_mailbox_if mbx_if ();

    assign mbx_if.cmd_wr      = cmd_wr;
    assign mbx_if.cmd_ch      = cmd_ch;
    assign mbx_if.cmd_data    = cmd_data;
    assign mbx_if.z80_addr    = z80_addr;
    assign mbx_if.z80_iorq_n  = iorq_n;
    assign mbx_if.z80_rd_n    = rd_n;
    assign mbx_if.z80_wr_n    = wr_n;
    assign mbx_if.z80_m1_n    = m1_n;
    assign mbx_if.z80_mreq_n  = mreq_n;
    assign mbx_if.z80_fetch_a = fetch_a;
    assign mbx_if.ext_irq_n   = ext_n;
    assign rd_w[gi]  = mbx_if.rd_data;
    assign sel_w[gi] = mbx_if.rd_sel;
    assign int_w[gi] = mbx_if.int_n;
    assign nmi_w[gi] = mbx_if.nmi_n;

    snd_cmd_mailbox #(
      .NUM_CH     (2),
      .DEPTH      ((gi == 1 || gi == 2) ? 4 : 1),
      .OVERWRITE  (gi != 2),
      .BASE_ADDR  (8'h02),
      .NMI_MASK   (4'b0010),
      .NMI_PERIOD ((gi == 3) ? 4096 : 0)
    ) u_dut (
      .CLK_32M (clk),
      .reset   (rst),
      .pause   (pause),
      .bus     (mbx_if),
      .ready   (ready_w[gi]),
      .ovf     (ovf_w[gi])
    );
  end

  typedef struct {
    logic       wr;
    logic [1:0] ch;
    logic [7:0] data;
    int         op;
    logic [7:0] addr;
    logic       ext_n;
    logic       pause;
    logic [7:0] exp_rd;
    logic       exp_sel;
    logic [1:0] exp_ready;
    logic [1:0] exp_ovf;
    logic       exp_int;
    logic       exp_nmi;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(input logic wr, input logic [1:0] ch, input logic [7:0] data,
                              input int op, input logic [7:0] addr, input logic e_n,
                              input logic pau, input logic [7:0] rd, input logic sel,
                              input logic [1:0] rdy, input logic [1:0] ov,
                              input logic i_n, input logic n_n);
    vec_t v;
    v.wr = wr; v.ch = ch; v.data = data; v.op = op; v.addr = addr;
    v.ext_n = e_n; v.pause = pau; v.exp_rd = rd; v.exp_sel = sel;
    v.exp_ready = rdy; v.exp_ovf = ov; v.exp_int = i_n; v.exp_nmi = n_n;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic set_io(input int op, input logic [7:0] a);
    iorq_n   = (op == OP_IDLE);
    rd_n     = (op != OP_IN);
    wr_n     = (op != OP_OUT);
    m1_n     = (op != OP_IM0);
    z80_addr = a;
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    cmd_wr = 1'b1; cmd_ch = ch; cmd_data = d;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic do_reset();
    cmd_wr = 1'b0; set_io(OP_IDLE, 8'h00); pause = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] vals  [5];
  logic [7:0] exp_b [4];
  logic [7:0] exp_c [4];

  initial begin
    rst = 1'b1; pause = 1'b0; cmd_wr = 1'b0; cmd_ch = 2'd0; cmd_data = 8'h00;
    ext_n = 1'b1; mreq_n = 1'b1; fetch_a = 16'h0000;
    set_io(OP_IDLE, 8'h00);

    //            wr ch data   op       addr  ext pau rd     sel rdy    ovf    int nmi
    vecs[0]  = mk(1, 0, 8'h5A, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b01, 2'b00, 0, 1);
    vecs[1]  = mk(0, 0, 8'h00, OP_IN,   8'h02, 1, 0, 8'h5A, 1, 2'b00, 2'b00, 1, 1);
    vecs[2]  = mk(0, 0, 8'h00, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b00, 2'b00, 1, 1);
    vecs[3]  = mk(0, 0, 8'h00, OP_IN,   8'h02, 1, 0, 8'hFF, 1, 2'b00, 2'b00, 1, 1);
    vecs[4]  = mk(0, 0, 8'h00, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b00, 2'b00, 1, 1);
    vecs[5]  = mk(1, 1, 8'hA1, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b10, 2'b00, 1, 0);
    vecs[6]  = mk(1, 1, 8'hB2, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b10, 2'b10, 1, 0);
    vecs[7]  = mk(0, 0, 8'h00, OP_IN,   8'h04, 1, 0, 8'hB2, 1, 2'b00, 2'b10, 1, 1);
    vecs[8]  = mk(0, 0, 8'h00, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b00, 2'b10, 1, 1);
    vecs[9]  = mk(1, 1, 8'hC3, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b10, 2'b10, 1, 0);
    vecs[10] = mk(0, 0, 8'h00, OP_OUT,  8'h05, 1, 0, 8'hFF, 0, 2'b00, 2'b00, 1, 1);
    vecs[11] = mk(0, 0, 8'h00, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b00, 2'b00, 1, 1);
    vecs[12] = mk(1, 3, 8'h77, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b00, 2'b00, 1, 1);
    vecs[13] = mk(1, 0, 8'h66, OP_IDLE, 8'h00, 0, 0, 8'hFF, 0, 2'b01, 2'b00, 0, 1);
    vecs[14] = mk(0, 0, 8'h00, OP_IM0,  8'h00, 0, 0, 8'hCF, 1, 2'b01, 2'b00, 0, 1);
    vecs[15] = mk(0, 0, 8'h00, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b01, 2'b00, 0, 1);
    vecs[16] = mk(1, 0, 8'h88, OP_IN,   8'h02, 1, 0, 8'h66, 1, 2'b01, 2'b00, 0, 1);
    vecs[17] = mk(0, 0, 8'h00, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b01, 2'b00, 0, 1);
    vecs[18] = mk(0, 0, 8'h00, OP_IN,   8'h02, 1, 0, 8'h88, 1, 2'b00, 2'b00, 1, 1);
    vecs[19] = mk(0, 0, 8'h00, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b00, 2'b00, 1, 1);
    vecs[20] = mk(1, 0, 8'h99, OP_IDLE, 8'h00, 1, 1, 8'hFF, 0, 2'b01, 2'b00, 0, 1);
    vecs[21] = mk(0, 0, 8'h00, OP_IN,   8'h02, 1, 1, 8'h99, 1, 2'b01, 2'b00, 0, 1);
    vecs[22] = mk(0, 0, 8'h00, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b01, 2'b00, 0, 1);
    vecs[23] = mk(0, 0, 8'h00, OP_IN,   8'h02, 1, 0, 8'h99, 1, 2'b00, 2'b00, 1, 1);
    vecs[24] = mk(0, 0, 8'h00, OP_IDLE, 8'h00, 1, 0, 8'hFF, 0, 2'b00, 2'b00, 1, 1);
    vecs[25] = mk(1, 1, 8'h10, OP_OUT,  8'h05, 1, 0, 8'hFF, 0, 2'b00, 2'b00, 1, 1);

    vals  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h55};
    exp_c = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset state
    tick();
    tick();
    chk("rst_rd", 0, rd_w[0], 8'hFF);
    chk("rst_sel", 0, 8'(sel_w[0]), 8'h00);
    chk("rst_ready", 0, 8'(ready_w[0]), 8'h00);
    chk("rst_ovf", 0, 8'(ovf_w[0]), 8'h00);
    chk("rst_int", 0, 8'(int_w[0]), 8'h01);
    chk("rst_nmi", 0, 8'(nmi_w[0]), 8'h01);
    chk("rst_nmi_tmr", 3, 8'(nmi_w[3]), 8'h01);
    rst = 1'b0;

    // Table-driven single-cycle vectors against the DEPTH=1 mailbox
    for (int i = 0; i < 26; i++) begin
      cmd_wr = vecs[i].wr; cmd_ch = vecs[i].ch; cmd_data = vecs[i].data;
      set_io(vecs[i].op, vecs[i].addr);
      ext_n = vecs[i].ext_n; pause = vecs[i].pause;
      #1;
      chk("vec_rd", i, rd_w[0], vecs[i].exp_rd);
      chk("vec_sel", i, 8'(sel_w[0]), 8'(vecs[i].exp_sel));
      tick();
      chk("vec_ready", i, 8'(ready_w[0]), 8'(vecs[i].exp_ready));
      chk("vec_ovf", i, 8'(ovf_w[0]), 8'(vecs[i].exp_ovf));
      chk("vec_int", i, 8'(int_w[0]), 8'(vecs[i].exp_int));
      chk("vec_nmi", i, 8'(nmi_w[0]), 8'(vecs[i].exp_nmi));
    end
    cmd_wr = 1'b0; set_io(OP_IDLE, 8'h00); ext_n = 1'b1; pause = 1'b0;
    tick();

    // Reset with data queued
    push(2'd0, 8'h42);
    chk("mid_ready_pre", 0, 8'(ready_w[0]), 8'h01);
    do_reset();
    set_io(OP_IN, 8'h02);
    #1;
    chk("mid_rd", 0, rd_w[0], 8'hFF);
    for (int d = 0; d < 3; d++) chk("mid_ready", d, 8'(ready_w[d]), 8'h00);
    tick();
    set_io(OP_IDLE, 8'h00);
    tick();

    // DEPTH=4: overflow in overwrite and drop modes
    do_reset();
    for (int k = 0; k < 5; k++) push(2'd0, vals[k]);
    chk("d4_ovf_b", 0, 8'(ovf_w[1]), 8'h01);
    chk("d4_ovf_c", 0, 8'(ovf_w[2]), 8'h01);
    chk("d4_ready_b", 0, 8'(ready_w[1]), 8'h01);
    for (int k = 0; k < 4; k++) begin
      set_io(OP_IN, 8'h02);
      #1;
      chk("d4_rd_b", k, rd_w[1], exp_b[k]);
      chk("d4_rd_c", k, rd_w[2], exp_c[k]);
      tick();
      set_io(OP_IDLE, 8'h00);
      tick();
    end
    chk("d4_empty_b", 0, 8'(ready_w[1]), 8'h00);
    chk("d4_empty_c", 0, 8'(ready_w[2]), 8'h00);
    chk("d4_ovf_sticky", 0, 8'(ovf_w[1]), 8'h01);

    // Ack port flush clears overflow
    set_io(OP_OUT, 8'h03);
    tick();
    set_io(OP_IDLE, 8'h00);
    tick();
    chk("ack_ovf_b", 0, 8'(ovf_w[1]), 8'h00);
    chk("ack_ovf_c", 0, 8'(ovf_w[2]), 8'h00);

    // Push into a full FIFO in the same cycle as a pop
    for (int k = 0; k < 4; k++) push(2'd0, vals[k]);
    chk("pp_full_ovf", 0, 8'(ovf_w[2]), 8'h00);
    cmd_wr = 1'b1; cmd_ch = 2'd0; cmd_data = 8'h55;
    set_io(OP_IN, 8'h02);
    #1;
    chk("pp_rd_b", 0, rd_w[1], 8'h11);
    chk("pp_rd_c", 0, rd_w[2], 8'h11);
    tick();
    cmd_wr = 1'b0; set_io(OP_IDLE, 8'h00);
    chk("pp_ovf_b", 0, 8'(ovf_w[1]), 8'h00);
    chk("pp_ovf_c", 0, 8'(ovf_w[2]), 8'h00);
    tick();
    for (int k = 0; k < 4; k++) begin
      set_io(OP_IN, 8'h02);
      #1;
      chk("pp_drain_b", k, rd_w[1], vals[k + 1]);
      chk("pp_drain_c", k, rd_w[2], vals[k + 1]);
      tick();
      set_io(OP_IDLE, 8'h00);
      tick();
    end
    chk("pp_empty_b", 0, 8'(ready_w[1]), 8'h00);
    chk("pp_empty_c", 0, 8'(ready_w[2]), 8'h00);

    // Periodic NMI with a pause window, then NMI acknowledge by fetch of 0x0066
    do_reset();
    repeat (2000) tick();
    pause = 1'b1;
    repeat (100) tick();
    chk("tmr_paused", 0, 8'(nmi_w[3]), 8'h01);
    pause = 1'b0;
    repeat (2095) tick();
    chk("tmr_before", 0, 8'(nmi_w[3]), 8'h01);
    tick();
    chk("tmr_fire", 0, 8'(nmi_w[3]), 8'h00);
    m1_n = 1'b0; mreq_n = 1'b0; fetch_a = 16'h0067;
    tick();
    chk("tmr_wrong_fetch", 0, 8'(nmi_w[3]), 8'h00);
    fetch_a = 16'h0066;
    tick();
    chk("tmr_ack", 0, 8'(nmi_w[3]), 8'h01);
    m1_n = 1'b1; mreq_n = 1'b1; fetch_a = 16'h0000;
    tick();
    chk("tmr_stay", 0, 8'(nmi_w[3]), 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
